xdma_finish_sender: RTL and testbench
=====================================

# xdma_finish_sender

Transmit-side counterpart of the xDMA finish manager. It accepts "send finish to previous hop" requests (remote address plus the DMA ID of the finished chained write) and buffers them in a small FIFO. Each request is serialised onto the inter-cluster finish link as a single-beat write, and the block holds the entry until the link's write response returns. On an error response it retries the beat a bounded number of times, then drops it. It sits between the finish manager's to-remote finish handshake and the xDMA AXI adapter's outbound write port.

## Interface
- `id_t`, default `logic`: DMA ID type.
- `addr_t`, default `logic`: remote address type.
- `data_t`, default `logic`: link data word; `$bits(data_t) >= $bits(id_t)`.
- `Depth`, default 4: request FIFO entries, >= 2.
- `MaxRetry`, default 3: resends after an error response before the entry is dropped, >= 1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `finish_valid_i`  in  1  finish request valid.
- `finish_ready_o`  out  1  request accepted when high with valid.
- `finish_dma_id_i`  in  `id_t`  DMA ID to report back.
- `finish_remote_addr_i`  in  `addr_t`  previous-hop finish address.
- `tx_valid_o`  out  1  link write beat valid.
- `tx_ready_i`  in  1  link accepts beat.
- `tx_addr_o`  out  `addr_t`  beat destination address.
- `tx_data_o`  out  `data_t`  finish word.
- `tx_resp_valid_i`  in  1  write response valid.
- `tx_resp_err_i`  in  1  response carries an error.
- `tx_resp_ready_o`  out  1  response accepted.
- `busy_o`  out  1  FSM not Idle or FIFO not empty.
- `pending_o`  out  `$clog2(Depth+1)`  FIFO occupancy.

## Operation
- FIFO
  - Push when `finish_valid_i & finish_ready_o`.
  - `finish_ready_o = ~full`, taken from registered occupancy only; a pop in the same cycle does not raise ready.
  - Read/write pointers wrap from `Depth-1` to 0 for any Depth.
  - Simultaneous push and pop leaves occupancy unchanged.
- Finish word
  - `tx_data_o` = head `dma_id` zero-extended to `data_t`.
  - `tx_addr_o` = head `remote_addr`.
  - Both outputs are valid only while `tx_valid_o` is high; they are 0 when the FIFO is empty.
- FSM states:
  - Idle: if FIFO not empty, go to Issue.
  - Issue: `tx_valid_o = 1`; on `tx_ready_i` go to WaitResp. Address and data stay stable while valid and not ready.
  - WaitResp: `tx_resp_ready_o = 1`. On `tx_resp_valid_i`:
    - If `!tx_resp_err_i`: pop the entry, clear the retry count, go to Idle.
    - If error and retry count < MaxRetry: increment the retry count, go to Issue.
    - If error and retry count = MaxRetry: pop (drop) the entry, clear the retry count, go to Idle.
- Retry counter width is `$clog2(MaxRetry+1)`.
- Only one beat is outstanding at a time. Responses arriving outside WaitResp are not accepted (`tx_resp_ready_o = 0`).
- `pending_o` counts the head entry until it is popped.

## Timing
- Reset values:
  - `finish_ready_o = 1`
  - `tx_valid_o = 0`, `tx_addr_o = 0`, `tx_data_o = 0`
  - `tx_resp_ready_o = 0`, `busy_o = 0`, `pending_o = 0`
  - FIFO empty, FSM in Idle, retry count 0.
- Latency: a request accepted in cycle N makes `tx_valid_o` high in cycle N+2 if the FSM is Idle.
- Pop happens at the response handshake edge. The next entry can issue 2 cycles after that.
- The minimum period per finish is 3 cycles plus link stall plus response latency.
- `tx_valid_o` never drops before `tx_ready_i`.
- Reset mid-operation: all state returns to reset values immediately. FIFO contents and any outstanding beat are discarded. No response is awaited after reset.

## Configuration
- `XDMA_FINISH_SENDER_STATS_EN`: when defined, the block adds two outputs:
  - `sent_cnt_o` out [31:0]: increments on each successful response and wraps at 2^32.
  - `drop_o` out 1: sticky, set when an entry is dropped after MaxRetry errors. Cleared only by reset.
  - Both reset to 0.
- When not defined, these ports and their registers do not exist, and the rest of the behaviour is identical.

## Test plan
- Single request: id=0x5, addr=0x1000_0040, `tx_ready_i` and response error-free immediately.
  - Required: `tx_valid_o` in cycle 2, `tx_data_o = 0x5`, `tx_addr_o = 0x1000_0040`, `pending_o` 1 then 0, `busy_o` low after the response.
- Fill: push 4 requests with Depth=4 and `tx_ready_i = 0`.
  - Required: `finish_ready_o` low after the 4th push, `pending_o = 4`; a 5th request is not accepted until after the first pop.
  - Required: ids drain in order, 4 pointer wraps across 8 requests.
- Stall: hold `tx_ready_i = 0` for 10 cycles.
  - Required: `tx_valid_o`, `tx_addr_o` and `tx_data_o` stable for all 10 cycles; exactly one beat issued.
- Retry: first 2 responses error, 3rd ok.
  - Required: 3 beats with identical addr/data, then pop; with the macro defined, `sent_cnt_o = 1` and `drop_o = 0`.
- Drop: MaxRetry=3 and 4 error responses.
  - Required: 4 beats issued, entry popped, next entry issued; with the macro defined, `drop_o = 1`.
- Reset while in WaitResp with 2 entries queued.
  - Required: all outputs return to reset values; a late response is not accepted.

Source files
------------

// File: rtl/xdma_finish_sender.sv
// xdma_finish_sender: queues "finish to previous hop" requests and sends each one as a
// single-beat write on the inter-cluster finish link. The head entry is held until its
// write response returns. Error responses are retried up to MaxRetry times, after which
// the entry is dropped.
// Optional feature macro: XDMA_FINISH_SENDER_STATS_EN adds sent_cnt_o and drop_o.
module xdma_finish_sender #(
    parameter type         id_t     = logic,
    parameter type         addr_t   = logic,
    parameter type         data_t   = logic,
    parameter int unsigned Depth    = 4,
    parameter int unsigned MaxRetry = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       finish_valid_i,
    output logic                       finish_ready_o,
    input  id_t                        finish_dma_id_i,
    input  addr_t                      finish_remote_addr_i,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output addr_t                      tx_addr_o,
    output data_t                      tx_data_o,
    input  logic                       tx_resp_valid_i,
    input  logic                       tx_resp_err_i,
    output logic                       tx_resp_ready_o,
    output logic                       busy_o,
    output logic [$clog2(Depth+1)-1:0] pending_o
`ifdef XDMA_FINISH_SENDER_STATS_EN
    ,
    output logic [31:0]                sent_cnt_o,
    output logic                       drop_o
`endif
);

    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned RetryW = $clog2(MaxRetry + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;

    state_e            state_q, state_d;
    id_t               id_mem_q   [Depth];
    addr_t             addr_mem_q [Depth];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              push, pop, full, empty;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // Ready comes from registered occupancy only; a same-cycle pop does not free a slot.
    assign full           = (count_q == CntW'(Depth));
    assign empty          = (count_q == '0);
    assign finish_ready_o = ~full;
    assign push           = finish_valid_i & ~full;

    // Request storage; contents are only observed after a push, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q]   <= finish_dma_id_i;
            addr_mem_q[wr_ptr_q] <= finish_remote_addr_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // FSM state and retry count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic: one beat in flight, pop only on the final response for the head.
    always_comb begin
        state_d         = state_q;
        retry_d         = retry_q;
        pop             = 1'b0;
        tx_valid_o      = 1'b0;
        tx_resp_ready_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) state_d = StIssue;
            end
            StIssue: begin
                tx_valid_o = 1'b1;
                if (tx_ready_i) state_d = StWaitResp;
            end
            StWaitResp: begin
                tx_resp_ready_o = 1'b1;
                if (tx_resp_valid_i) begin
                    if (!tx_resp_err_i || (retry_q == RetryW'(MaxRetry))) begin
                        pop     = 1'b1;
                        retry_d = '0;
                        state_d = StIdle;
                    end else begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat payload is forced to zero whenever no beat is offered.
    assign tx_addr_o = tx_valid_o ? addr_mem_q[rd_ptr_q] : '0;
    assign tx_data_o = tx_valid_o ? data_t'(id_mem_q[rd_ptr_q]) : '0;
    assign busy_o    = (state_q != StIdle) | ~empty;
    assign pending_o = count_q;

`ifdef XDMA_FINISH_SENDER_STATS_EN
    logic [31:0] sent_cnt_q;
    logic        drop_q;

    // Success counter wraps naturally; drop flag is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_cnt_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            if (pop && !tx_resp_err_i) sent_cnt_q <= sent_cnt_q + 32'd1;
            if (pop && tx_resp_err_i)  drop_q     <= 1'b1;
        end
    end

    assign sent_cnt_o = sent_cnt_q;
    assign drop_o     = drop_q;
`endif

endmodule

// File: tb/tb_xdma_finish_sender.sv
// Self-checking bench for xdma_finish_sender: directed scenarios plus a randomized run
// checked against a queue-based model of the request/retry rules.
`timescale 1ns/1ps
module tb_xdma_finish_sender;

    localparam int unsigned Depth    = 4;
    localparam int unsigned MaxRetry = 3;

    typedef logic [7:0]  id_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef struct packed { id_t id; addr_t addr; } req_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        finish_valid_i = 1'b0;
    logic        finish_ready_o;
    id_t         finish_dma_id_i = '0;
    addr_t       finish_remote_addr_i = '0;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    addr_t       tx_addr_o;
    data_t       tx_data_o;
    logic        tx_resp_valid_i = 1'b0;
    logic        tx_resp_err_i = 1'b0;
    logic        tx_resp_ready_o;
    logic        busy_o;
    logic [2:0]  pending_o;
`ifdef XDMA_FINISH_SENDER_STATS_EN
    logic [31:0] sent_cnt_o;
    logic        drop_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    xdma_finish_sender #(
        .id_t    (id_t),
        .addr_t  (addr_t),
        .data_t  (data_t),
        .Depth   (Depth),
        .MaxRetry(MaxRetry)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .finish_valid_i      (finish_valid_i),
        .finish_ready_o      (finish_ready_o),
        .finish_dma_id_i     (finish_dma_id_i),
        .finish_remote_addr_i(finish_remote_addr_i),
        .tx_valid_o          (tx_valid_o),
        .tx_ready_i          (tx_ready_i),
        .tx_addr_o           (tx_addr_o),
        .tx_data_o           (tx_data_o),
        .tx_resp_valid_i     (tx_resp_valid_i),
        .tx_resp_err_i       (tx_resp_err_i),
        .tx_resp_ready_o     (tx_resp_ready_o),
        .busy_o              (busy_o),
        .pending_o           (pending_o)
`ifdef XDMA_FINISH_SENDER_STATS_EN
        ,
        .sent_cnt_o          (sent_cnt_o),
        .drop_o              (drop_o)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        finish_valid_i       = 1'b0;
        finish_dma_id_i      = '0;
        finish_remote_addr_i = '0;
        tx_ready_i           = 1'b0;
        tx_resp_valid_i      = 1'b0;
        tx_resp_err_i        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (finish_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", finish_ready_o); end
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid_o); end
        total++; if (tx_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%0h want=0", tx_addr_o); end
        total++; if (tx_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h want=0", tx_data_o); end
        total++; if (tx_resp_ready_o !== 1'b0) begin bad++; $display("FAIL reset_resp_ready got=%0b want=0", tx_resp_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_o); end
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending_o); end
`ifdef XDMA_FINISH_SENDER_STATS_EN
        total++; if (sent_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_sent got=%0d want=0", sent_cnt_o); end
        total++; if (drop_o !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0b want=0", drop_o); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        finish_valid_i = 1'b1; finish_dma_id_i = 8'h05; finish_remote_addr_i = 32'h1000_0040;
        total++; if (finish_ready_o !== 1'b1) begin bad++; $display("FAIL single_accept got=%0b want=1", finish_ready_o); end
        tick();
        idle_inputs();
        total++; if (pending_o !== 3'd1) begin bad++; $display("FAIL single_pending1 got=%0d want=1", pending_o); end
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", tx_valid_o); end
        tick();
        total++; if (tx_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid_c2 got=%0b want=1", tx_valid_o); end
        total++; if (tx_data_o !== 32'h5) begin bad++; $display("FAIL single_data got=%0h want=5", tx_data_o); end
        total++; if (tx_addr_o !== 32'h1000_0040) begin bad++; $display("FAIL single_addr got=%0h want=10000040", tx_addr_o); end
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        total++; if (tx_resp_ready_o !== 1'b1) begin bad++; $display("FAIL single_resp_ready got=%0b want=1", tx_resp_ready_o); end
        total++; if (pending_o !== 3'd1) begin bad++; $display("FAIL single_pending_held got=%0d want=1", pending_o); end
        tx_resp_valid_i = 1'b1; tx_resp_err_i = 1'b0;
        tick();
        tx_resp_valid_i = 1'b0;
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL single_pending0 got=%0d want=0", pending_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b want=0", busy_o); end
        total++; if (tx_resp_ready_o !== 1'b0) begin bad++; $display("FAIL single_resp_ready_off got=%0b want=0", tx_resp_ready_o); end
    endtask

    task automatic test_fill();
        req_t exp_q[$];
        req_t r;
        int   next_id = 0;
        int   pops = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++; if (finish_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0b want=1", i, finish_ready_o); end
            r.id = 8'(8'h10 + i); r.addr = 32'h2000_0000 + 32'(i * 16);
            finish_valid_i = 1'b1; finish_dma_id_i = r.id; finish_remote_addr_i = r.addr;
            exp_q.push_back(r);
            tick();
        end
        next_id = 4;
        finish_dma_id_i = 8'h14; finish_remote_addr_i = 32'h2000_0040;
        total++; if (finish_ready_o !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%0b want=0", finish_ready_o); end
        total++; if (pending_o !== 3'd4) begin bad++; $display("FAIL fill_pending got=%0d want=4", pending_o); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (finish_ready_o !== 1'b0) begin bad++; $display("FAIL fill_hold_ready got=%0b want=0", finish_ready_o); end
        end
        tx_ready_i = 1'b1;
        for (int cyc = 0; cyc < 300 && (next_id < 8 || exp_q.size() != 0); cyc++) begin
            finish_valid_i       = (next_id < 8);
            finish_dma_id_i      = 8'(8'h10 + next_id);
            finish_remote_addr_i = 32'h2000_0000 + 32'(next_id * 16);
            tx_resp_valid_i      = tx_resp_ready_o;
            tx_resp_err_i        = 1'b0;
            if (tx_valid_o) begin
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL fill_spurious_beat got=%0h want=none", tx_data_o);
                end else begin
                    total++; if (tx_data_o !== {24'h0, exp_q[0].id}) begin bad++; $display("FAIL fill_order got=%0h want=%0h", tx_data_o, exp_q[0].id); end
                    total++; if (tx_addr_o !== exp_q[0].addr) begin bad++; $display("FAIL fill_addr got=%0h want=%0h", tx_addr_o, exp_q[0].addr); end
                end
            end
            if (finish_valid_i && finish_ready_o) begin
                total++; if (pops == 0) begin bad++; $display("FAIL fill_early_accept got=%0d want>0", pops); end
                r.id = finish_dma_id_i; r.addr = finish_remote_addr_i;
                exp_q.push_back(r);
                next_id++;
            end
            if (tx_resp_valid_i && tx_resp_ready_o && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
            tick();
        end
        idle_inputs();
        total++; if (pops !== 8) begin bad++; $display("FAIL fill_pops got=%0d want=8", pops); end
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL fill_drained got=%0d want=0", pending_o); end
    endtask

    task automatic test_stall();
        int beats = 0;
        do_reset();
        finish_valid_i = 1'b1; finish_dma_id_i = 8'hA7; finish_remote_addr_i = 32'h3000_0100;
        tick();
        idle_inputs();
        for (int k = 0; k < 5 && !tx_valid_o; k++) tick();
        total++; if (tx_valid_o !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%0b want=1", tx_valid_o); end
        for (int k = 0; k < 10; k++) begin
            total++; if (tx_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid_%0d got=%0b want=1", k, tx_valid_o); end
            total++; if (tx_data_o !== 32'hA7) begin bad++; $display("FAIL stall_data_%0d got=%0h want=a7", k, tx_data_o); end
            total++; if (tx_addr_o !== 32'h3000_0100) begin bad++; $display("FAIL stall_addr_%0d got=%0h want=30000100", k, tx_addr_o); end
            tick();
        end
        tx_ready_i = 1'b1;
        if (tx_valid_o) beats++;
        tick();
        tx_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (tx_valid_o) beats++;
            tick();
        end
        total++; if (beats !== 1) begin bad++; $display("FAIL stall_beats got=%0d want=1", beats); end
        tx_resp_valid_i = 1'b1;
        tick();
        tx_resp_valid_i = 1'b0;
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL stall_pop got=%0d want=0", pending_o); end
    endtask

    task automatic test_retry();
        int beats = 0;
        int resps = 0;
        bit done = 1'b0;
        do_reset();
        finish_valid_i = 1'b1; finish_dma_id_i = 8'h3C; finish_remote_addr_i = 32'h4000_0080;
        tick();
        idle_inputs();
        for (int k = 0; k < 100 && !done; k++) begin
            tx_ready_i      = 1'b1;
            tx_resp_valid_i = tx_resp_ready_o;
            tx_resp_err_i   = (resps < 2);
            if (tx_valid_o) begin
                beats++;
                total++; if (tx_data_o !== 32'h3C) begin bad++; $display("FAIL retry_data got=%0h want=3c", tx_data_o); end
                total++; if (tx_addr_o !== 32'h4000_0080) begin bad++; $display("FAIL retry_addr got=%0h want=40000080", tx_addr_o); end
            end
            if (tx_resp_ready_o) begin
                resps++;
                if (!tx_resp_err_i) done = 1'b1;
            end
            tick();
        end
        idle_inputs();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL retry_timeout got=%0b want=1", done); end
        total++; if (beats !== 3) begin bad++; $display("FAIL retry_beats got=%0d want=3", beats); end
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL retry_pop got=%0d want=0", pending_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL retry_busy got=%0b want=0", busy_o); end
`ifdef XDMA_FINISH_SENDER_STATS_EN
        total++; if (sent_cnt_o !== 32'd1) begin bad++; $display("FAIL retry_sent got=%0d want=1", sent_cnt_o); end
        total++; if (drop_o !== 1'b0) begin bad++; $display("FAIL retry_drop got=%0b want=0", drop_o); end
`endif
    endtask

    task automatic test_drop();
        int a_beats = 0;
        int a_errs = 0;
        bit a_done = 1'b0;
        bit b_seen = 1'b0;
        bit b_done = 1'b0;
        do_reset();
        finish_valid_i = 1'b1; finish_dma_id_i = 8'h51; finish_remote_addr_i = 32'h5000_0000;
        tick();
        finish_dma_id_i = 8'h62; finish_remote_addr_i = 32'h6000_0000;
        tick();
        idle_inputs();
        for (int k = 0; k < 200 && !b_done; k++) begin
            tx_ready_i      = 1'b1;
            tx_resp_valid_i = tx_resp_ready_o;
            tx_resp_err_i   = !a_done;
            if (tx_valid_o) begin
                if (!a_done) begin
                    a_beats++;
                    total++; if (tx_data_o !== 32'h51) begin bad++; $display("FAIL drop_a_data got=%0h want=51", tx_data_o); end
                end else begin
                    b_seen = 1'b1;
                    total++; if (tx_data_o !== 32'h62) begin bad++; $display("FAIL drop_b_data got=%0h want=62", tx_data_o); end
                end
            end
            if (tx_resp_ready_o) begin
                if (!a_done) begin
                    a_errs++;
                    if (a_errs == MaxRetry + 1) a_done = 1'b1;
                end else begin
                    b_done = 1'b1;
                end
            end
            tick();
        end
        idle_inputs();
        total++; if (a_beats !== 4) begin bad++; $display("FAIL drop_beats got=%0d want=4", a_beats); end
        total++; if (b_seen !== 1'b1) begin bad++; $display("FAIL drop_next_issued got=%0b want=1", b_seen); end
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL drop_pending got=%0d want=0", pending_o); end
`ifdef XDMA_FINISH_SENDER_STATS_EN
        total++; if (drop_o !== 1'b1) begin bad++; $display("FAIL drop_flag got=%0b want=1", drop_o); end
        total++; if (sent_cnt_o !== 32'd1) begin bad++; $display("FAIL drop_sent got=%0d want=1", sent_cnt_o); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        finish_valid_i = 1'b1; finish_dma_id_i = 8'h71; finish_remote_addr_i = 32'h7000_0000;
        tick();
        finish_dma_id_i = 8'h72; finish_remote_addr_i = 32'h7000_0010;
        tick();
        idle_inputs();
        tx_ready_i = 1'b1;
        for (int k = 0; k < 10 && !tx_resp_ready_o; k++) tick();
        tx_ready_i = 1'b0;
        total++; if (tx_resp_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_waitresp got=%0b want=1", tx_resp_ready_o); end
        total++; if (pending_o !== 3'd2) begin bad++; $display("FAIL rmid_queued got=%0d want=2", pending_o); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if (finish_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b want=1", finish_ready_o); end
        total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", tx_valid_o); end
        total++; if (tx_addr_o !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%0h want=0", tx_addr_o); end
        total++; if (tx_data_o !== 32'h0) begin bad++; $display("FAIL rmid_data got=%0h want=0", tx_data_o); end
        total++; if (tx_resp_ready_o !== 1'b0) begin bad++; $display("FAIL rmid_resp_ready got=%0b want=0", tx_resp_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy_o); end
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL rmid_pending got=%0d want=0", pending_o); end
        tick();
        rst_ni = 1'b1;
        tx_resp_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (tx_resp_ready_o !== 1'b0) begin bad++; $display("FAIL rmid_late_resp got=%0b want=0", tx_resp_ready_o); end
            total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_no_beat got=%0b want=0", tx_valid_o); end
            total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL rmid_empty got=%0d want=0", pending_o); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        req_t       q[$];
        req_t       r;
        int         attempts = 0;
        int         sent = 0;
        int         idle_run = 0;
        bit         dropped = 1'b0;
        bit         outst = 1'b0;
        bit         prev_stall = 1'b0;
        bit         drain;
        bit         do_push, do_issue, do_resp;
        logic [2:0] exp_pend;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drain    = (cyc >= 1200);
            exp_pend = 3'(q.size());
            total++; if (pending_o !== exp_pend) begin bad++; $display("FAIL rnd_pending c=%0d got=%0d want=%0d", cyc, pending_o, exp_pend); end
            total++; if (finish_ready_o !== (q.size() < Depth)) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", cyc, finish_ready_o, q.size() < Depth); end
            total++; if (busy_o !== (q.size() != 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", cyc, busy_o, q.size() != 0); end
            total++; if (tx_resp_ready_o !== outst) begin bad++; $display("FAIL rnd_resp_ready c=%0d got=%0b want=%0b", cyc, tx_resp_ready_o, outst); end
            if (outst) begin
                total++; if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_two_outstanding c=%0d got=%0b want=0", cyc, tx_valid_o); end
            end
            if (prev_stall) begin
                total++; if (tx_valid_o !== 1'b1) begin bad++; $display("FAIL rnd_valid_dropped c=%0d got=%0b want=1", cyc, tx_valid_o); end
            end
            if (q.size() == 0) begin
                total++; if ({tx_valid_o, tx_addr_o, tx_data_o} !== 65'h0) begin bad++; $display("FAIL rnd_empty_out c=%0d got=%0b/%0h/%0h want=0", cyc, tx_valid_o, tx_addr_o, tx_data_o); end
            end else if (tx_valid_o) begin
                total++; if (tx_data_o !== {24'h0, q[0].id}) begin bad++; $display("FAIL rnd_data c=%0d got=%0h want=%0h", cyc, tx_data_o, q[0].id); end
                total++; if (tx_addr_o !== q[0].addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%0h want=%0h", cyc, tx_addr_o, q[0].addr); end
            end
            if (q.size() != 0 && !outst && !tx_valid_o) begin
                idle_run++;
                total++; if (idle_run > 1) begin bad++; $display("FAIL rnd_issue_latency c=%0d got=%0d want<=1", cyc, idle_run); end
            end else begin
                idle_run = 0;
            end
`ifdef XDMA_FINISH_SENDER_STATS_EN
            total++; if (sent_cnt_o !== 32'(sent)) begin bad++; $display("FAIL rnd_sent c=%0d got=%0d want=%0d", cyc, sent_cnt_o, sent); end
            total++; if (drop_o !== dropped) begin bad++; $display("FAIL rnd_drop c=%0d got=%0b want=%0b", cyc, drop_o, dropped); end
`endif
            finish_valid_i       = !drain && ($urandom_range(0, 1) == 1);
            finish_dma_id_i      = 8'($urandom);
            finish_remote_addr_i = $urandom;
            tx_ready_i           = ($urandom_range(0, 9) < 6);
            tx_resp_valid_i      = ($urandom_range(0, 1) == 1);
            tx_resp_err_i        = !drain && ($urandom_range(0, 9) < 3);
            do_push    = finish_valid_i & finish_ready_o;
            do_issue   = tx_valid_o & tx_ready_i;
            do_resp    = tx_resp_ready_o & tx_resp_valid_i;
            prev_stall = tx_valid_o & !tx_ready_i;
            if (do_issue) outst = 1'b1;
            if (do_resp) begin
                outst = 1'b0;
                if (!tx_resp_err_i) begin
                    if (q.size() != 0) void'(q.pop_front());
                    attempts = 0;
                    sent++;
                end else if (attempts == MaxRetry) begin
                    if (q.size() != 0) void'(q.pop_front());
                    attempts = 0;
                    dropped  = 1'b1;
                end else begin
                    attempts++;
                end
            end
            if (do_push) begin
                r.id = finish_dma_id_i; r.addr = finish_remote_addr_i;
                q.push_back(r);
            end
            tick();
        end
        idle_inputs();
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_not_drained got=%0d want=0", q.size()); end
        total++; if (pending_o !== 3'd0) begin bad++; $display("FAIL rnd_final_pending got=%0d want=0", pending_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_retry();
        test_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
